input_bridge_dual_port: RTL and testbench

//  Host-to-core injection bridge, mirror of the dual-port output bridge. Two host write ports each

---
 rtl/input_bridge_dual_port.sv | 182 ++++++++++++++++++
 tb/tb_input_bridge_dual_port.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_bridge_dual_port.sv
// input_bridge_dual_port
//
// Host-to-core injection bridge. Two host write ports each pick a core input
// path by index and push words into that path's staging FIFO. Every path
// drains into the overlay core under credit-based flow control. Each credit
// stands for one free slot in the core-side input FIFO, and the core returns
// credits one at a time on c_in.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-low reset
//   conf_en  : configuration in progress; blocks host writes and core sends
//   port0/1  : path index selected by host port 0 / 1
//   wr_en0/1 : write strobe, host port 0 / 1
//   d_in0/1  : write data, host port 0 / 1 (payload above bit 0, last-tag at bit 0)
//   busy0/1  : a write on that host port this cycle would be dropped
//   d_out    : flattened core paths; slice i = {word, metadata}, metadata bit 0 = valid
//   c_in     : credit return from the core, one bit per path per cycle
//   err      : sticky flag for credit overflow or a write while busy

module input_bridge_dual_port #(
  parameter int NUM_PORTS   = 20,
  parameter int DATA_W      = 33,
  parameter int META_BITS   = 1,
  parameter int STAGE_DEPTH = 4,
  parameter int CREDITS     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    conf_en,
  input  logic [4:0]                              port0,
  input  logic [4:0]                              port1,
  input  logic                                    wr_en0,
  input  logic                                    wr_en1,
  input  logic [DATA_W-1:0]                       d_in0,
  input  logic [DATA_W-1:0]                       d_in1,
  output logic                                    busy0,
  output logic                                    busy1,
  output logic [NUM_PORTS*(DATA_W+META_BITS)-1:0] d_out,
  input  logic [NUM_PORTS-1:0]                    c_in,
  output logic                                    err
);

  localparam int SLICE_W = DATA_W + META_BITS;
  localparam int PTR_W   = (STAGE_DEPTH > 1) ? $clog2(STAGE_DEPTH) : 1;
  localparam int CNT_W   = $clog2(STAGE_DEPTH + 1);
  localparam int CRD_W   = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(STAGE_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
  localparam logic [CRD_W-1:0]     CRD_MAX    = CRD_W'(CREDITS);
  localparam logic [CRD_W-1:0]     CRD_ONE    = CRD_W'(1);
  localparam logic [META_BITS-1:0] META_VALID = META_BITS'(1);

  // Staging storage and per-path state
  logic [DATA_W-1:0]            mem_q    [NUM_PORTS][STAGE_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]             wr_ptr_d [NUM_PORTS];
  logic [PTR_W-1:0]             rd_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]             rd_ptr_d [NUM_PORTS];
  logic [CNT_W-1:0]             count_q  [NUM_PORTS];
  logic [CNT_W-1:0]             count_d  [NUM_PORTS];
  logic [CRD_W-1:0]             credit_q [NUM_PORTS];
  logic [CRD_W-1:0]             credit_d [NUM_PORTS];
  logic [NUM_PORTS*SLICE_W-1:0] d_out_q;
  logic [NUM_PORTS*SLICE_W-1:0] d_out_d;
  logic                         err_q;
  logic                         err_d;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] enq;
  logic [NUM_PORTS-1:0] fire;
  logic [DATA_W-1:0]    enq_data [NUM_PORTS];
  logic                 sel0_full;
  logic                 sel1_full;
  logic                 bad0;
  logic                 bad1;
  logic                 acc0;
  logic                 acc1;
  logic                 ovf;

  // Host side. Busy is based on the FIFO count before the edge. The full
  // lookup goes through a loop so that an out-of-range index never reads
  // past the end of the array. On a same-path collision, port 0 wins.
  always_comb begin
    sel0_full = 1'b0;
    sel1_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i] = (count_q[i] == CNT_FULL);
      if (32'(port0) == i) sel0_full = full[i];
      if (32'(port1) == i) sel1_full = full[i];
    end
    bad0  = (32'(port0) >= NUM_PORTS);
    bad1  = (32'(port1) >= NUM_PORTS);
    busy0 = conf_en | bad0 | sel0_full;
    busy1 = conf_en | bad1 | sel1_full | (wr_en0 & (port0 == port1));
    acc0  = wr_en0 & ~busy0;
    acc1  = wr_en1 & ~busy1;
  end

  // Per-path enqueue, send decision, pointer, count and credit updates.
  // When a send and a credit return land on the same path in the same
  // cycle, they cancel out. A credit returned to a path whose counter is
  // already full is ignored and flagged instead.
  always_comb begin
    enq     = '0;
    fire    = '0;
    ovf     = 1'b0;
    d_out_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      enq_data[i] = d_in1;
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      credit_d[i] = credit_q[i];

      if (acc0 && (32'(port0) == i)) begin
        enq[i]      = 1'b1;
        enq_data[i] = d_in0;
      end else if (acc1 && (32'(port1) == i)) begin
        enq[i]      = 1'b1;
        enq_data[i] = d_in1;
      end

      fire[i] = ~conf_en & (count_q[i] != '0) & (credit_q[i] != '0);

      if (enq[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
      if (fire[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
        d_out_d[i*SLICE_W +: SLICE_W] = {mem_q[i][rd_ptr_q[i]], META_VALID};
      end

      case ({enq[i], fire[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_ONE;
        2'b01:   count_d[i] = count_q[i] - CNT_ONE;
        default: count_d[i] = count_q[i];
      endcase

      if (fire[i] && !c_in[i]) begin
        credit_d[i] = credit_q[i] - CRD_ONE;
      end else if (!fire[i] && c_in[i]) begin
        if (credit_q[i] == CRD_MAX) ovf = 1'b1;
        else                        credit_d[i] = credit_q[i] + CRD_ONE;
      end
    end
    err_d = err_q | (wr_en0 & busy0) | (wr_en1 & busy1) | ovf;
  end

  // Staging storage needs no reset. The pointers and counts decide what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= enq_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        credit_q[i] <= CRD_MAX;
      end
      d_out_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
        credit_q[i] <= credit_d[i];
      end
      d_out_q <= d_out_d;
      err_q   <= err_d;
    end
  end

  assign d_out = d_out_q;
  assign err   = err_q;

endmodule

// File: tb/tb_input_bridge_dual_port.sv
// tb_input_bridge_dual_port
//
// Testbench for input_bridge_dual_port. A queue-based reference model holds
// each path's staged words and credit count. The model is advanced once per
// clock edge and its results are compared against the DUT.

module tb_input_bridge_dual_port;

  localparam int NP      = 20;
  localparam int DW      = 33;
  localparam int SW      = 34;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          conf_en = 1'b0;
  logic [4:0]    port0   = '0;
  logic [4:0]    port1   = '0;
  logic          wr_en0  = 1'b0;
  logic          wr_en1  = 1'b0;
  logic [DW-1:0] d_in0   = '0;
  logic [DW-1:0] d_in1   = '0;
  logic          busy0;
  logic          busy1;
  logic          err;
  logic [NP*SW-1:0] d_out;
  logic [NP-1:0] c_in = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0]    mq [NP][$];
  int               m_credit [NP];
  logic             m_err;
  logic [NP*SW-1:0] m_dout;
  logic [NP*SW-1:0] m_mask;
  logic [NP*SW-1:0] vmask;

  input_bridge_dual_port dut (
    .clk     (clk),
    .rst     (rst),
    .conf_en (conf_en),
    .port0   (port0),
    .port1   (port1),
    .wr_en0  (wr_en0),
    .wr_en1  (wr_en1),
    .d_in0   (d_in0),
    .d_in1   (d_in1),
    .busy0   (busy0),
    .busy1   (busy1),
    .d_out   (d_out),
    .c_in    (c_in),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    return {1'($urandom), 32'($urandom)};
  endfunction

  function automatic bit exp_busy(input logic [4:0] p, input bit collide);
    if (conf_en) return 1'b1;
    if (p >= NP) return 1'b1;
    if (mq[p].size() >= DEPTH) return 1'b1;
    return collide;
  endfunction

  function automatic bit exp_busy0();
    return exp_busy(port0, 1'b0);
  endfunction

  function automatic bit exp_busy1();
    return exp_busy(port1, wr_en0 && (port0 == port1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      m_credit[i] = CREDITS;
    end
    m_err  = 1'b0;
    m_dout = '0;
    m_mask = vmask;
  endtask

  // Works out what the DUT should produce at the coming edge, using the inputs currently applied.
  task automatic model_edge();
    bit b0;
    bit b1;
    b0 = exp_busy0();
    b1 = exp_busy1();
    m_dout = '0;
    m_mask = vmask;
    for (int i = 0; i < NP; i++) begin
      bit f;
      f = !conf_en && (mq[i].size() != 0) && (m_credit[i] != 0);
      if (f) begin
        m_dout[i*SW +: SW] = {mq[i].pop_front(), 1'b1};
        m_mask[i*SW +: SW] = '1;
      end
      if (f && !c_in[i]) m_credit[i]--;
      else if (!f && c_in[i]) begin
        if (m_credit[i] == CREDITS) m_err = 1'b1;
        else m_credit[i]++;
      end
    end
    if (wr_en0) begin
      if (b0) m_err = 1'b1;
      else mq[port0].push_back(d_in0);
    end
    if (wr_en1) begin
      if (b1) m_err = 1'b1;
      else mq[port1].push_back(d_in1);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    conf_en = 1'b0;
    port0   = '0;
    port1   = '0;
    wr_en0  = 1'b0;
    wr_en1  = 1'b0;
    d_in0   = '0;
    d_in1   = '0;
    c_in    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Random inputs. When clean is set, the model is used to avoid any write or credit that would raise err.
  task automatic rand_inputs(input bit clean);
    idle();
    conf_en = ($urandom_range(0, 15) == 0);
    port0   = 5'($urandom_range(0, clean ? NP - 1 : 23));
    port1   = ($urandom_range(0, 3) == 0) ? port0 : 5'($urandom_range(0, clean ? NP - 1 : 23));
    d_in0   = rand_word();
    d_in1   = rand_word();
    wr_en0  = 1'($urandom);
    if (clean && exp_busy0()) wr_en0 = 1'b0;
    wr_en1  = 1'($urandom);
    if (clean && exp_busy1()) wr_en1 = 1'b0;
    for (int i = 0; i < NP; i++) begin
      c_in[i] = ($urandom_range(0, 2) == 0) &&
                ((m_credit[i] < CREDITS) || (!clean && $urandom_range(0, 30) == 0));
    end
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    c_in = '1;
    tick();
    idle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pre_err got=%b exp=1", err);
    end
    for (int n = 0; n < 10; n++) begin
      rand_inputs(1'b0);
      tick();
    end
    idle();
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (d_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dout got=%h exp=0", d_out);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy got=%b%b exp=00", busy0, busy1);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err got=%b exp=0", err);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      idle();
      if (n < 5) begin
        wr_en0 = 1'b1;
        port0  = 5'd0;
        d_in0  = rand_word();
      end
      tick();
      if (d_out[0]) pulses++;
      checks++;
      if ((d_out & m_mask) !== m_dout) begin
        errors++;
        $display("[TB] FAIL reset_path0_dout got=%h exp=%h", d_out & m_mask, m_dout);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("[TB] FAIL reset_path0_sends got=%0d exp=4", pulses);
    end
  endtask

  task automatic test_single_path();
    logic [SW-1:0] exp_slice;
    do_reset();
    exp_slice = {33'h1_0000_0001, 1'b1};
    wr_en0 = 1'b1;
    port0  = 5'd3;
    d_in0  = 33'h1_0000_0001;
    tick();
    idle();
    checks++;
    if (d_out[3*SW] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early_valid got=%b exp=0", d_out[3*SW]);
    end
    tick();
    checks++;
    if (d_out[3*SW +: SW] !== exp_slice) begin
      errors++;
      $display("[TB] FAIL single_slice got=%h exp=%h", d_out[3*SW +: SW], exp_slice);
    end
    tick();
    checks++;
    if (d_out[3*SW] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pulse_width got=%b exp=0", d_out[3*SW]);
    end
  endtask

  task automatic test_credit_starvation();
    int pulses;
    do_reset();
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      idle();
      if (n < 6) begin
        wr_en1 = 1'b1;
        port1  = 5'd7;
        d_in1  = rand_word();
      end
      tick();
      if (d_out[7*SW]) pulses++;
      checks++;
      if ((d_out & m_mask) !== m_dout) begin
        errors++;
        $display("[TB] FAIL starve_dout got=%h exp=%h", d_out & m_mask, m_dout);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("[TB] FAIL starve_first_sends got=%0d exp=4", pulses);
    end
    for (int n = 0; n < 6; n++) begin
      idle();
      if (n < 2) c_in[7] = 1'b1;
      tick();
      if (d_out[7*SW]) pulses++;
    end
    checks++;
    if (pulses !== 6) begin
      errors++;
      $display("[TB] FAIL starve_total_sends got=%0d exp=6", pulses);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] wa;
    int pulses;
    do_reset();
    wa = rand_word();
    wr_en0 = 1'b1;
    wr_en1 = 1'b1;
    port0  = 5'd5;
    port1  = 5'd5;
    d_in0  = wa;
    d_in1  = ~wa;
    #1;
    checks++;
    if (busy1 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_busy got=%b%b exp=01", busy0, busy1);
    end
    tick();
    idle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_err got=%b exp=1", err);
    end
    tick();
    checks++;
    if (d_out[5*SW +: SW] !== {wa, 1'b1}) begin
      errors++;
      $display("[TB] FAIL collide_word got=%h exp=%h", d_out[5*SW +: SW], {wa, 1'b1});
    end
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (d_out[5*SW]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL collide_extra_sends got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [4];
    logic [DW-1:0] got [$];
    do_reset();
    for (int n = 0; n < 4; n++) begin
      idle();
      wr_en0 = 1'b1;
      port0  = 5'd2;
      d_in0  = rand_word();
      tick();
    end
    idle();
    tick();
    for (int n = 0; n < 4; n++) begin
      words[n] = rand_word();
      idle();
      wr_en0 = 1'b1;
      port0  = 5'd2;
      d_in0  = words[n];
      tick();
      checks++;
      if (d_out[2*SW] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall_valid got=%b exp=0", d_out[2*SW]);
      end
    end
    idle();
    wr_en0 = 1'b1;
    port0  = 5'd2;
    d_in0  = 33'h0_DEAD_BEEF;
    #1;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_busy got=%b exp=1", busy0);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_err got=%b exp=1", err);
    end
    for (int n = 0; n < 8; n++) begin
      idle();
      if (n < 4) c_in[2] = 1'b1;
      tick();
      if (d_out[2*SW]) got.push_back(d_out[2*SW+1 +: DW]);
    end
    checks++;
    if (got.size() !== 4) begin
      errors++;
      $display("[TB] FAIL bp_count got=%0d exp=4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== words[k]) begin
          errors++;
          $display("[TB] FAIL bp_order_%0d got=%h exp=%h", k, got[k], words[k]);
        end
      end
    end
  endtask

  task automatic test_conf();
    int pulses;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      idle();
      wr_en0 = 1'b1;
      port0  = 5'd4;
      d_in0  = rand_word();
      tick();
    end
    idle();
    conf_en = 1'b1;
    port0   = 5'd4;
    port1   = 5'd6;
    #1;
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL conf_busy got=%b%b exp=11", busy0, busy1);
    end
    for (int n = 0; n < 3; n++) begin
      c_in[4] = (n < 2);
      tick();
      checks++;
      if ((d_out & vmask) !== '0) begin
        errors++;
        $display("[TB] FAIL conf_no_valid got=%h exp=0", d_out & vmask);
      end
    end
    idle();
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (d_out[4*SW]) pulses++;
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("[TB] FAIL conf_resume_sends got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    c_in[0] = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_pre_err got=%b exp=0", err);
    end
    tick();
    idle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_err got=%b exp=1", err);
    end
  endtask

  task automatic test_random(input bit clean, input int cycles);
    do_reset();
    for (int n = 0; n < cycles; n++) begin
      rand_inputs(clean);
      #1;
      checks++;
      if (busy0 !== exp_busy0() || busy1 !== exp_busy1()) begin
        errors++;
        $display("[TB] FAIL rand_busy got=%b%b exp=%b%b", busy0, busy1, exp_busy0(), exp_busy1());
      end
      tick();
      checks++;
      if ((d_out & m_mask) !== m_dout) begin
        errors++;
        $display("[TB] FAIL rand_dout got=%h exp=%h", d_out & m_mask, m_dout);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("[TB] FAIL rand_err got=%b exp=%b", err, m_err);
      end
    end
  endtask

  initial begin
    vmask = '0;
    for (int i = 0; i < NP; i++) vmask[i*SW] = 1'b1;
    model_reset();
    $display("[TB] starting input_bridge_dual_port bench");
    test_reset();
    test_single_path();
    test_credit_starvation();
    test_collision();
    test_backpressure();
    test_conf();
    test_credit_overflow();
    test_random(1'b1, 1500);
    test_random(1'b0, 1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
